instr_feeder: RTL and testbench
===============================

INSTR_FEEDER -- requirements
Module: instr_feeder

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-002 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port: load_we  input  1  program-memory write enable.
REQ-004 SHALL have port: load_addr  input  4  program-memory write address.
REQ-005 SHALL have port: load_data  input  16  instruction word; opcode[15:12], s4[11:8], s3[7:4], s2[3:0].
REQ-006 SHALL have port: start  input  1  begin a run from address 0.
REQ-007 SHALL have port: step_req  input  1  operator step request; used only per REQ-027.
REQ-008 SHALL have port: redirect_valid  input  1  taken jump/branch from decode.
REQ-009 SHALL have port: redirect_addr  input  16  new PC; only bits [3:0] are used.
REQ-010 SHALL have port: instr_ready  input  1  decode stage accepts instr.
REQ-011 SHALL have port: instr_valid  output  1  instr holds a valid word.
REQ-012 SHALL have port: instr  output  16  issued instruction word.
REQ-013 SHALL have port: instr_addr  output  4  address of the word on instr.
REQ-014 SHALL have port: busy  output  1  high in FETCH or ISSUE.
REQ-015 SHALL have port: halted  output  1  high in HALT.
REQ-016 SHALL have port: issue_count  output  8  accepted-transfer count.

Function
REQ-017 SHALL have states IDLE, FETCH, ISSUE, HALT; ptr is a 4-bit fetch pointer.
REQ-018 SHALL write mem[load_addr] <= load_data when load_we is high in IDLE or HALT, and ignore load_we in FETCH/ISSUE.
REQ-019 SHALL, on start in IDLE or HALT, set ptr=0, clear issue_count, and enter FETCH next cycle; start in FETCH/ISSUE is ignored.
REQ-020 SHALL in FETCH register instr<=mem[ptr], instr_addr<=ptr and go to ISSUE; instr_valid rises 2 cycles after start is sampled.
REQ-021 SHALL assert instr_valid only in ISSUE and hold instr stable until instr_valid&&instr_ready (transfer).
REQ-022 SHALL on transfer: ptr<=ptr+1 (15 wraps to 0), issue_count+1 saturating at 255, then go to HALT if instr[15:12]==4'd15, else FETCH; peak throughput is one word per 2 cycles.
REQ-023 SHALL on redirect_valid in FETCH, or in ISSUE without transfer: ptr<=redirect_addr[3:0], discard the held word (no count), and go to FETCH.
REQ-024 SHALL on redirect_valid coincident with a transfer: count the transfer, load ptr from redirect_addr[3:0]; a halt opcode still enters HALT.
REQ-025 SHALL ignore redirect_valid in IDLE and HALT.

Reset
REQ-026 SHALL on rst: state=IDLE, ptr=0, instr=0, instr_addr=0, instr_valid=0, busy=0, halted=0, issue_count=0, step flag cleared; memory contents are not cleared; rst wins over all other inputs, including mid-run.

Configuration
REQ-027 SHALL, with INSTR_FEEDER_SINGLE_STEP_EN defined: set a pending flag on each step_req rising edge, leave FETCH only when the flag is set, and clear the flag on entering ISSUE.
REQ-028 SHALL, without INSTR_FEEDER_SINGLE_STEP_EN, ignore step_req and run per REQ-020.

Structure
REQ-029 SHALL place the state enum, OPC_HALT=4'd15, field bit positions, and depth 16 in package instr_feeder_pkg.
REQ-030 SHALL implement storage as sub-module instr_mem: 16x16, synchronous write, asynchronous read.

Verification
REQ-031 SHALL cover: load 0x1123,0x2234,0xF000 at addresses 0-2, start, instr_ready=1 -> issue order 0x1123,0x2234,0xF000; halted=1; issue_count=3.
REQ-032 SHALL cover: instr_ready=0 for 5 cycles in ISSUE -> instr and instr_addr are constant, and issue_count is unchanged.
REQ-033 SHALL cover: redirect_valid=1 with redirect_addr=0x0009 while in ISSUE without transfer -> next valid instr_addr=9 and issue_count is unchanged.
REQ-034 SHALL cover: 16 non-halt words, run 17 transfers -> instr_addr wraps 15 to 0; issue_count=17.
REQ-035 SHALL cover: rst asserted during ISSUE -> all outputs return to 0 next cycle; a subsequent start reissues mem[0] unchanged.
REQ-036 SHALL cover, with the macro defined: no step_req -> instr_valid stays 0; two step_req pulses -> exactly two words issued.

Source files
------------

// File: rtl/instr_feeder_pkg.sv
// Shared types and constants for the instruction feeder: FSM states, word
// layout, memory geometry and the halt opcode.
package instr_feeder_pkg;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;
   localparam int WORD_W = 16;
   localparam int CNT_W  = 8;

   // Instruction word layout: opcode[15:12], s4[11:8], s3[7:4], s2[3:0].
   localparam int OPC_HI = 15;
   localparam int OPC_LO = 12;
   localparam int S4_HI  = 11;
   localparam int S4_LO  = 8;
   localparam int S3_HI  = 7;
   localparam int S3_LO  = 4;
   localparam int S2_HI  = 3;
   localparam int S2_LO  = 0;

   localparam logic [3:0]       OPC_HALT  = 4'd15;
   localparam logic [CNT_W-1:0] COUNT_MAX = 8'd255;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_ISSUE = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   typedef struct packed {
      logic [OPC_HI-OPC_LO:0] opcode;
      logic [S4_HI-S4_LO:0]   s4;
      logic [S3_HI-S3_LO:0]   s3;
      logic [S2_HI-S2_LO:0]   s2;
   } instr_t;

   function automatic logic [3:0] opcode_of(input logic [WORD_W-1:0] word);
      instr_t fields;
      fields = instr_t'(word);
      return fields.opcode;
   endfunction

   function automatic logic is_halt(input logic [WORD_W-1:0] word);
      return opcode_of(word) == OPC_HALT;
   endfunction

endpackage

// File: rtl/instr_feeder_mem.sv
// Program store for the instruction feeder: 16 words of 16 bits with a
// synchronous write port and an asynchronous read port. Contents survive reset.
module instr_mem
   import instr_feeder_pkg::*;
(
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/instr_feeder.sv
// Instruction feeder: fetches words from a small program store and hands them to
// decode over a valid/ready link. Optional macro INSTR_FEEDER_SINGLE_STEP_EN
// gates each fetch on an operator step request.
module instr_feeder
   import instr_feeder_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load_we,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [WORD_W-1:0] load_data,
   input  logic              start,
   input  logic              step_req,
   input  logic              redirect_valid,
   input  logic [15:0]       redirect_addr,
   input  logic              instr_ready,
   output logic              instr_valid,
   output logic [WORD_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_addr,
   output logic              busy,
   output logic              halted,
   output logic [CNT_W-1:0]  issue_count
);

   // Handshake: instr_valid is high for the whole of ISSUE and instr/instr_addr
   // hold still until the cycle where instr_valid && instr_ready (a transfer);
   // valid never drops without a transfer except on redirect or reset.

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [WORD_W-1:0] mem_rdata;
   logic              mem_we;
   logic              transfer;
   logic              step_ok;
   logic [ADDR_W-1:0] redirect_ptr;
   logic [CNT_W-1:0]  count_next;
   logic              unused_redirect_hi;

   // The store is writable only while nothing is being fetched from it.
   assign mem_we = load_we && !rst && ((state == ST_IDLE) || (state == ST_HALT));

   instr_mem u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (load_addr),
      .wdata (load_data),
      .raddr (ptr),
      .rdata (mem_rdata)
   );

   assign transfer           = (state == ST_ISSUE) && instr_valid && instr_ready;
   assign redirect_ptr       = redirect_addr[ADDR_W-1:0];
   assign unused_redirect_hi = ^redirect_addr[15:ADDR_W];
   assign count_next         = (issue_count == COUNT_MAX) ? issue_count : issue_count + 8'd1;

`ifdef INSTR_FEEDER_SINGLE_STEP_EN
   logic step_q;
   logic step_pending;
   logic fetch_go;

   assign fetch_go = (state == ST_FETCH) && !redirect_valid && step_pending;

   // A rising edge arriving in the same cycle as a consumed request stays pending.
   always_ff @(posedge clk) begin
      if (rst) begin
         step_q       <= 1'b0;
         step_pending <= 1'b0;
      end else begin
         step_q <= step_req;
         if (step_req && !step_q) begin
            step_pending <= 1'b1;
         end else if (fetch_go) begin
            step_pending <= 1'b0;
         end
      end
   end

   assign step_ok = step_pending;
`else
   logic unused_step;

   assign unused_step = step_req;
   assign step_ok     = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         ptr         <= '0;
         instr       <= '0;
         instr_addr  <= '0;
         instr_valid <= 1'b0;
         busy        <= 1'b0;
         halted      <= 1'b0;
         issue_count <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_HALT: begin
               if (start) begin
                  state       <= ST_FETCH;
                  ptr         <= '0;
                  issue_count <= '0;
                  busy        <= 1'b1;
                  halted      <= 1'b0;
               end
            end

            ST_FETCH: begin
               if (redirect_valid) begin
                  ptr <= redirect_ptr;
               end else if (step_ok) begin
                  state       <= ST_ISSUE;
                  instr       <= mem_rdata;
                  instr_addr  <= ptr;
                  instr_valid <= 1'b1;
               end
            end

            ST_ISSUE: begin
               if (transfer) begin
                  issue_count <= count_next;
                  instr_valid <= 1'b0;
                  ptr         <= redirect_valid ? redirect_ptr : ptr + 4'd1;
                  // A halt word is still counted and still honours a redirect.
                  if (is_halt(instr)) begin
                     state  <= ST_HALT;
                     busy   <= 1'b0;
                     halted <= 1'b1;
                  end else begin
                     state <= ST_FETCH;
                  end
               end else if (redirect_valid) begin
                  ptr         <= redirect_ptr;
                  instr_valid <= 1'b0;
                  state       <= ST_FETCH;
               end
            end

            default: begin
               state       <= ST_IDLE;
               instr_valid <= 1'b0;
               busy        <= 1'b0;
               halted      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_feeder.sv
// Self-checking bench for instr_feeder: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model of the program store and feeder.
module tb_instr_feeder;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_we;
   logic [3:0]  load_addr;
   logic [15:0] load_data;
   logic        start;
   logic        step_req;
   logic        redirect_valid;
   logic [15:0] redirect_addr;
   logic        instr_ready;
   logic        instr_valid;
   logic [15:0] instr;
   logic [3:0]  instr_addr;
   logic        busy;
   logic        halted;
   logic [7:0]  issue_count;

   int checks = 0;
   int errors = 0;

   logic [15:0] ref_mem [16];
   logic [15:0] exp_q[$];
   logic [3:0]  exp_addr_q[$];

   always #5 clk = ~clk;

   instr_feeder dut (
      .clk            (clk),
      .rst            (rst),
      .load_we        (load_we),
      .load_addr      (load_addr),
      .load_data      (load_data),
      .start          (start),
      .step_req       (step_req),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .instr_ready    (instr_ready),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_addr     (instr_addr),
      .busy           (busy),
      .halted         (halted),
      .issue_count    (issue_count)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic [3:0] a, input logic [15:0] d);
      load_we   = 1'b1;
      load_addr = a;
      load_data = d;
      ref_mem[a] = d;
      tick();
      load_we = 1'b0;
   endtask

   // Leaves the DUT in ISSUE holding mem[0]; caller chooses instr_ready.
   task automatic reset_and_start();
      rst = 1'b1;
      tick();
      rst   = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
   endtask

   function automatic logic [15:0] rand_word(input bit allow_halt);
      logic [3:0] op;
      op = 4'($urandom_range(0, 14));
      if (allow_halt && ($urandom_range(0, 5) == 0)) op = 4'hF;
      return {op, 12'($urandom)};
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b1;
      tick();
      tick();
      checks++;
      if ({instr_valid, busy, halted} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags got %b want 000", {instr_valid, busy, halted});
      end
      checks++;
      if (instr !== 16'h0000 || instr_addr !== 4'h0) begin
         errors++;
         $display("FAIL reset_instr got %h/%h want 0000/0", instr, instr_addr);
      end
      checks++;
      if (issue_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_count got %0d want 0", issue_count);
      end
      rst   = 1'b0;
      start = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0 || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset got busy=%b valid=%b want 0/0", busy, instr_valid);
      end
   endtask

`ifndef INSTR_FEEDER_SINGLE_STEP_EN
   task automatic test_program_order();
      int t;
      int last_t;
      logic [15:0] w;
      logic [3:0]  a;
      load_word(4'd0, 16'h1123);
      load_word(4'd1, 16'h2234);
      load_word(4'd2, 16'hF000);
      exp_q = {16'h1123, 16'h2234, 16'hF000};
      exp_addr_q = {4'd0, 4'd1, 4'd2};
      instr_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (instr_valid !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL start_fetch got valid=%b busy=%b want 0/1", instr_valid, busy);
      end
      tick();
      checks++;
      if (instr_valid !== 1'b1) begin
         errors++;
         $display("FAIL start_latency got valid=%b want 1", instr_valid);
      end
      t = 0;
      last_t = -1;
      while (exp_q.size() > 0 && t < 20) begin
         if (instr_valid) begin
            w = exp_q.pop_front();
            a = exp_addr_q.pop_front();
            checks++;
            if (instr !== w || instr_addr !== a) begin
               errors++;
               $display("FAIL issue_order got %h@%0d want %h@%0d", instr, instr_addr, w, a);
            end
            if (last_t >= 0) begin
               checks++;
               if (t - last_t != 2) begin
                  errors++;
                  $display("FAIL throughput got gap %0d want 2", t - last_t);
               end
            end
            last_t = t;
         end
         tick();
         t++;
      end
      instr_ready = 1'b0;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL order_timeout got %0d words left want 0", exp_q.size());
      end
      checks++;
      if ({halted, busy, instr_valid} !== 3'b100) begin
         errors++;
         $display("FAIL halt_state got h/b/v=%b want 100", {halted, busy, instr_valid});
      end
      checks++;
      if (issue_count !== 8'd3) begin
         errors++;
         $display("FAIL halt_count got %0d want 3", issue_count);
      end
   endtask

   task automatic test_wrap_and_saturate();
      int n;
      int t;
      for (int i = 0; i < 16; i++) load_word(4'(i), rand_word(1'b0));
      instr_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      t = 0;
      while (n < 260 && t < 700) begin
         if (instr_valid) begin
            checks++;
            if (instr_addr !== 4'(n % 16) || instr !== ref_mem[n % 16]) begin
               errors++;
               $display("FAIL wrap_word n=%0d got %h@%0d want %h@%0d",
                        n, instr, instr_addr, ref_mem[n % 16], n % 16);
            end
            n++;
            tick();
            t++;
            if (n == 17) begin
               checks++;
               if (issue_count !== 8'd17) begin
                  errors++;
                  $display("FAIL wrap_count got %0d want 17", issue_count);
               end
            end
            if (n == 255 || n == 260) begin
               checks++;
               if (issue_count !== 8'd255) begin
                  errors++;
                  $display("FAIL count_saturate n=%0d got %0d want 255", n, issue_count);
               end
            end
         end else begin
            tick();
            t++;
         end
      end
      instr_ready = 1'b0;
      checks++;
      if (n != 260) begin
         errors++;
         $display("FAIL wrap_timeout got %0d transfers want 260", n);
      end
   endtask

   task automatic test_stall();
      instr_ready = 1'b0;
      reset_and_start();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (instr_valid !== 1'b1 || instr !== ref_mem[0] || instr_addr !== 4'd0 ||
             issue_count !== 8'd0) begin
            errors++;
            $display("FAIL stall_hold cyc=%0d got v=%b %h@%0d cnt=%0d want 1 %h@0 cnt=0",
                     i, instr_valid, instr, instr_addr, issue_count, ref_mem[0]);
         end
         tick();
      end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      checks++;
      if (issue_count !== 8'd1) begin
         errors++;
         $display("FAIL stall_release got %0d want 1", issue_count);
      end
   endtask

   task automatic test_redirect();
      instr_ready = 1'b0;
      reset_and_start();
      redirect_valid = 1'b1;
      redirect_addr = {12'($urandom), 4'h9};
      tick();
      redirect_valid = 1'b0;
      checks++;
      if (instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL redirect_drop got valid=%b want 0", instr_valid);
      end
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr_addr !== 4'd9 || instr !== ref_mem[9] ||
          issue_count !== 8'd0) begin
         errors++;
         $display("FAIL redirect_issue got v=%b %h@%0d cnt=%0d want 1 %h@9 cnt=0",
                  instr_valid, instr, instr_addr, issue_count, ref_mem[9]);
      end
      // Redirect coincident with a transfer: counted, pointer taken from redirect.
      instr_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_addr = {12'($urandom), 4'h4};
      tick();
      instr_ready = 1'b0;
      redirect_valid = 1'b0;
      checks++;
      if (issue_count !== 8'd1) begin
         errors++;
         $display("FAIL redirect_xfer_count got %0d want 1", issue_count);
      end
      tick();
      checks++;
      if (instr_addr !== 4'd4 || instr !== ref_mem[4]) begin
         errors++;
         $display("FAIL redirect_xfer_addr got %h@%0d want %h@4", instr, instr_addr, ref_mem[4]);
      end
      // Redirect while fetching.
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_addr = 16'h000C;
      tick();
      redirect_valid = 1'b0;
      checks++;
      if (instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL fetch_redirect_hold got valid=%b want 0", instr_valid);
      end
      tick();
      checks++;
      if (instr_addr !== 4'd12 || instr !== ref_mem[12] || issue_count !== 8'd2) begin
         errors++;
         $display("FAIL fetch_redirect got %h@%0d cnt=%0d want %h@12 cnt=2",
                  instr, instr_addr, issue_count, ref_mem[12]);
      end
   endtask

   task automatic test_halt_and_restart();
      logic [15:0] nw;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      load_word(4'd5, 16'hF0AB);
      instr_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      redirect_valid = 1'b1;
      redirect_addr = 16'h0005;
      tick();
      redirect_valid = 1'b0;
      tick();
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      checks++;
      if ({halted, busy} !== 2'b10 || issue_count !== 8'd1) begin
         errors++;
         $display("FAIL halt_opcode got h/b=%b cnt=%0d want 10 cnt=1", {halted, busy}, issue_count);
      end
      redirect_valid = 1'b1;
      redirect_addr = 16'h0003;
      tick();
      checks++;
      if (halted !== 1'b1 || instr_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL halt_ignores_redirect got h=%b v=%b b=%b want 1/0/0", halted, instr_valid, busy);
      end
      // In HALT: load is accepted and start wins over redirect.
      nw = rand_word(1'b0);
      load_we = 1'b1;
      load_addr = 4'd0;
      load_data = nw;
      ref_mem[0] = nw;
      start = 1'b1;
      redirect_addr = 16'h0007;
      tick();
      load_we = 1'b0;
      start = 1'b0;
      redirect_valid = 1'b0;
      checks++;
      if (issue_count !== 8'd0 || busy !== 1'b1 || halted !== 1'b0) begin
         errors++;
         $display("FAIL restart_clear got cnt=%0d b=%b h=%b want 0/1/0", issue_count, busy, halted);
      end
      tick();
      checks++;
      if (instr_addr !== 4'd0 || instr !== nw) begin
         errors++;
         $display("FAIL halt_load_restart got %h@%0d want %h@0", instr, instr_addr, nw);
      end
   endtask

   task automatic test_rst_midrun();
      logic [15:0] keep;
      instr_ready = 1'b0;
      reset_and_start();
      keep = ref_mem[0];
      rst = 1'b1;
      start = 1'b1;
      redirect_valid = 1'b1;
      redirect_addr = 16'h0003;
      instr_ready = 1'b1;
      load_we = 1'b1;
      load_addr = 4'd0;
      load_data = ~keep;
      tick();
      checks++;
      if ({instr_valid, busy, halted, instr, instr_addr, issue_count} !== 31'd0) begin
         errors++;
         $display("FAIL rst_midrun got v=%b b=%b h=%b %h@%0d cnt=%0d want all 0",
                  instr_valid, busy, halted, instr, instr_addr, issue_count);
      end
      rst = 1'b0;
      start = 1'b0;
      redirect_valid = 1'b0;
      instr_ready = 1'b0;
      load_we = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr_addr !== 4'd0 || instr !== keep) begin
         errors++;
         $display("FAIL reissue_after_rst got v=%b %h@%0d want 1 %h@0", instr_valid, instr, instr_addr, keep);
      end
   endtask

   task automatic test_random();
      logic       m_running;
      logic       m_valid;
      logic       m_halted;
      logic       halt_op;
      logic [3:0] m_ptr;
      int         m_count;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 16; i++) load_word(4'(i), rand_word(1'b1));
      m_running = 1'b0;
      m_valid   = 1'b0;
      m_halted  = 1'b0;
      m_ptr     = 4'd0;
      m_count   = 0;
      for (int c = 0; c < 600; c++) begin
         checks++;
         if ({instr_valid, busy, halted} !== {m_valid, m_running, m_halted}) begin
            errors++;
            $display("FAIL rand_flags cyc=%0d got v/b/h=%b want %b", c,
                     {instr_valid, busy, halted}, {m_valid, m_running, m_halted});
         end
         checks++;
         if (issue_count !== 8'(m_count)) begin
            errors++;
            $display("FAIL rand_count cyc=%0d got %0d want %0d", c, issue_count, m_count);
         end
         if (m_valid) begin
            checks++;
            if (instr !== ref_mem[m_ptr] || instr_addr !== m_ptr) begin
               errors++;
               $display("FAIL rand_word cyc=%0d got %h@%0d want %h@%0d", c, instr, instr_addr,
                        ref_mem[m_ptr], m_ptr);
            end
         end
         instr_ready    = ($urandom_range(0, 2) != 0);
         redirect_valid = ($urandom_range(0, 5) == 0);
         redirect_addr  = 16'($urandom);
         start          = m_running ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
         load_we        = ($urandom_range(0, 3) == 0);
         load_addr      = 4'($urandom);
         load_data      = rand_word(1'b1);
         if (!m_running) begin
            if (load_we) ref_mem[load_addr] = load_data;
            if (start) begin
               m_running = 1'b1;
               m_halted  = 1'b0;
               m_ptr     = 4'd0;
               m_count   = 0;
               m_valid   = 1'b0;
            end
         end else if (!m_valid) begin
            if (redirect_valid) m_ptr = redirect_addr[3:0];
            else m_valid = 1'b1;
         end else if (instr_ready) begin
            if (m_count < 255) m_count++;
            halt_op = (ref_mem[m_ptr][15:12] == 4'hF);
            m_ptr   = redirect_valid ? redirect_addr[3:0] : m_ptr + 4'd1;
            m_valid = 1'b0;
            if (halt_op) begin
               m_running = 1'b0;
               m_halted  = 1'b1;
            end
         end else if (redirect_valid) begin
            m_ptr   = redirect_addr[3:0];
            m_valid = 1'b0;
         end
         tick();
      end
      instr_ready = 1'b0;
      redirect_valid = 1'b0;
      start = 1'b0;
      load_we = 1'b0;
   endtask
`endif

`ifdef INSTR_FEEDER_SINGLE_STEP_EN
   task automatic test_single_step();
      int xfers;
      logic [3:0] exp_a;
      load_word(4'd0, rand_word(1'b0));
      load_word(4'd1, rand_word(1'b0));
      load_word(4'd2, rand_word(1'b0));
      instr_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL step_hold cyc=%0d got valid=%b want 0", i, instr_valid);
         end
         tick();
      end
      xfers = 0;
      exp_a = 4'd0;
      for (int i = 0; i < 30; i++) begin
         step_req = (i == 0) || (i == 12);
         if (instr_valid) begin
            checks++;
            if (instr_addr !== exp_a || instr !== ref_mem[exp_a]) begin
               errors++;
               $display("FAIL step_word got %h@%0d want %h@%0d", instr, instr_addr, ref_mem[exp_a], exp_a);
            end
            exp_a = exp_a + 4'd1;
            xfers++;
         end
         tick();
      end
      step_req = 1'b0;
      checks++;
      if (xfers != 2 || issue_count !== 8'd2) begin
         errors++;
         $display("FAIL step_count got %0d xfers cnt=%0d want 2/2", xfers, issue_count);
      end
   endtask
`endif

   initial begin
      rst = 1'b1;
      load_we = 1'b0;
      load_addr = 4'd0;
      load_data = 16'h0000;
      start = 1'b0;
      step_req = 1'b0;
      redirect_valid = 1'b0;
      redirect_addr = 16'h0000;
      instr_ready = 1'b0;
      test_reset();
`ifdef INSTR_FEEDER_SINGLE_STEP_EN
      test_single_step();
`else
      test_program_order();
      test_wrap_and_saturate();
      test_stall();
      test_redirect();
      test_halt_and_restart();
      test_rst_midrun();
      test_random();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
